// File: rtl/fp_writeback_unit.sv
// fp_writeback_unit: 2-entry FP result buffer feeding the FP/integer register-file write ports, plus fflags/frm/fcsr CSRs.
// Optional macro FP_WB_BYPASS_EN: a result reaching an empty, unstalled buffer retires in the same cycle.
package fp_writeback_unit_pkg;
   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  fflags;
      logic [4:0]  rd;
      logic        fp_to_int;
   } wb_entry_t;
endpackage

module fp_writeback_unit
   import fp_writeback_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_result,
   input  logic [4:0]  ex_fflags,
   input  logic [4:0]  ex_rd,
   input  logic        ex_fp_to_int,
   input  logic        wb_stall,
   output logic        fp_wb_en,
   output logic [4:0]  fp_wb_addr,
   output logic [31:0] fp_wb_data,
   output logic        int_wb_en,
   output logic [4:0]  int_wb_addr,
   output logic [31:0] int_wb_data,
   input  logic        csr_we,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic [2:0]  frm,
   output logic [4:0]  fflags
);
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = 2;
   localparam logic [11:0] CSR_FFLAGS = 12'h001;
   localparam logic [11:0] CSR_FRM    = 12'h002;
   localparam logic [11:0] CSR_FCSR   = 12'h003;

   wb_entry_t        mem [DEPTH];
   wb_entry_t        in_entry;
   wb_entry_t        head;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_ptr_q, rd_ptr_q;
   logic [4:0]       fflags_q, fflags_d;
   logic [2:0]       frm_q, frm_d;
   logic             fifo_retire, bypass, push, store, retire;
   logic             unused_csr_wdata;

   assign unused_csr_wdata = ^csr_wdata[31:8];

   // Handshake, retire selection and write-port drive
   always_comb begin
      in_entry.result    = ex_result;
      in_entry.fflags    = ex_fflags;
      in_entry.rd        = ex_rd;
      in_entry.fp_to_int = ex_fp_to_int;
      fifo_retire = (count_q != '0) && !wb_stall;
      ex_ready    = (count_q < CNT_W'(DEPTH)) || fifo_retire;
      push        = ex_valid && ex_ready;
`ifdef FP_WB_BYPASS_EN
      bypass      = push && (count_q == '0) && !wb_stall && rst_n;
`else
      bypass      = 1'b0;
`endif
      store       = push && !bypass;
      retire      = fifo_retire || bypass;
      head        = bypass ? in_entry : mem[rd_ptr_q];
      count_d     = count_q + CNT_W'(store) - CNT_W'(fifo_retire);

      fp_wb_en    = retire && !head.fp_to_int;
      fp_wb_addr  = head.rd;
      fp_wb_data  = head.result;
      int_wb_en   = retire && head.fp_to_int && (head.rd != '0);
      int_wb_addr = head.rd;
      int_wb_data = head.result;
   end

   // CSR update; retiring flags are ORed in after any CSR write so none are lost
   always_comb begin
      fflags_d = fflags_q;
      frm_d    = frm_q;
      if (csr_we) begin
         case (csr_addr)
            CSR_FFLAGS: fflags_d = csr_wdata[4:0];
            CSR_FRM:    frm_d    = csr_wdata[2:0];
            CSR_FCSR: begin
               frm_d    = csr_wdata[7:5];
               fflags_d = csr_wdata[4:0];
            end
            default: ;
         endcase
      end
      if (retire) fflags_d = fflags_d | head.fflags;
   end

   always_comb begin
      case (csr_addr)
         CSR_FFLAGS: csr_rdata = 32'(fflags_q);
         CSR_FRM:    csr_rdata = 32'(frm_q);
         CSR_FCSR:   csr_rdata = 32'({frm_q, fflags_q});
         default:    csr_rdata = '0;
      endcase
   end

   assign frm    = frm_q;
   assign fflags = fflags_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         fflags_q <= '0;
         frm_q    <= '0;
      end else begin
         count_q  <= count_d;
         fflags_q <= fflags_d;
         frm_q    <= frm_d;
         if (store)       wr_ptr_q <= ~wr_ptr_q;
         if (fifo_retire) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   // Payload storage needs no reset; occupancy alone qualifies it
   always_ff @(posedge clk) begin
      if (store) mem[wr_ptr_q] <= in_entry;
   end
endmodule

// File: doc/fp_writeback_unit.md
FP_WRITEBACK_UNIT -- requirements
Module: fp_writeback_unit

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: ex_valid  input  1  execute stage presents a completed FP result.
REQ-004 SHALL provide: ex_ready  output  1  unit can accept the result this cycle.
REQ-005 SHALL provide: ex_result  input  32  result word from the FP execute stage.
REQ-006 SHALL provide: ex_fflags  input  5  exception flags for that result (NV,DZ,OF,UF,NX = bits 4..0).
REQ-007 SHALL provide: ex_rd  input  5  destination register index.
REQ-008 SHALL provide: ex_fp_to_int  input  1  1 = destination is the integer file, 0 = the FP file.
REQ-009 SHALL provide: wb_stall  input  1  register-file write port busy; no retire this cycle.
REQ-010 SHALL provide: fp_wb_en / fp_wb_addr / fp_wb_data  output  1/5/32  FP register-file write port.
REQ-011 SHALL provide: int_wb_en / int_wb_addr / int_wb_data  output  1/5/32  integer register-file write port.
REQ-012 SHALL provide: csr_we  input  1, csr_addr  input  12, csr_wdata  input  32  CSR write port.
REQ-013 SHALL provide: csr_rdata  output  32  combinational read of the CSR at csr_addr.
REQ-014 SHALL provide: frm  output  3  current dynamic rounding mode, fed to the execute stage rm.
REQ-015 SHALL provide: fflags  output  5  current sticky accrued exception flags.

Function
REQ-016 SHALL buffer results in a 2-entry FIFO holding {result, fflags, rd, fp_to_int}; accept = ex_valid && ex_ready.
REQ-017 SHALL drive ex_ready = (occupancy < 2) || (occupancy == 2 && retire this cycle).
REQ-018 SHALL retire the head entry in any cycle where the FIFO is non-empty and wb_stall = 0.
REQ-019 SHALL, on retire, assert exactly one write enable: fp_wb_en if head fp_to_int = 0, otherwise int_wb_en; data and address come from the head entry.
REQ-020 SHALL suppress int_wb_en when the head rd = 0; the flags SHALL still accrue.
REQ-021 SHALL hold both write enables low when the FIFO is empty or wb_stall = 1; data outputs are don't-care then.
REQ-022 SHALL OR the retiring entry's fflags into the sticky fflags register on the retire clock edge.
REQ-023 SHALL decode the CSRs as: 0x001 fflags = wdata[4:0]; 0x002 frm = wdata[2:0]; 0x003 fcsr = {frm, fflags} = wdata[7:0].
REQ-024 SHALL zero-extend csr_rdata for these addresses and return 0 for every other address.
REQ-025 SHALL, on a simultaneous CSR write to fflags/fcsr and a retire, store (csr_wdata flags | retiring flags), so no exception is lost.
REQ-026 SHALL accept a push and a retire in the same cycle when full; occupancy stays 2 and FIFO order is preserved.
REQ-027 SHALL keep occupancy in 0..2; pointers are 1 bit and wrap.

Reset
REQ-028 SHALL, while rst_n = 0, clear the FIFO (occupancy 0), fflags = 0 and frm = 0, with all write enables low and ex_ready = 1.
REQ-029 SHALL, when reset asserts mid-operation, discard pending entries without any write-back.

Configuration
REQ-030 SHALL support macro FP_WB_BYPASS_EN.
- Defined: an accepted entry arriving at an empty FIFO with wb_stall = 0 retires in the same cycle (0-cycle latency) and is not stored.
- Undefined: every entry is stored first and retires no earlier than the next cycle (1-cycle latency).

Verification
REQ-031 SHALL cover: push result 0x3F800000, rd=5, fp_to_int=0, no stall -> fp_wb_en with addr 5 and data 0x3F800000 after 1 cycle (0 cycles with bypass); int_wb_en stays 0.
REQ-032 SHALL cover: wb_stall=1 during three pushes -> ex_ready=0 after two accepts; release stall -> retires in order A, B, then C.
REQ-033 SHALL cover: retire entries with flags 0x01 then 0x10 -> fflags=0x11; read csr 0x003 with frm=3'b010 -> csr_rdata=0x51.
REQ-034 SHALL cover: csr_we to 0x001 with wdata 0 in the same cycle as a retire with flags 0x04 -> fflags=0x04.
REQ-035 SHALL cover: fp_to_int=1 with rd=0 -> no int_wb_en pulse, while the entry's flags still accrue.
REQ-036 SHALL cover: rst_n low with 2 entries pending -> no writes, ex_ready=1, fflags=0 and frm=0 after release.
